// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among four sources.
// Latency: Req in cycle t -> Gnt/Ld_Reg/Bus registered in t+1; Hold stalls new grants.
module regfile_write_arbiter #(
   parameter int W = 16
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [3:0]     Req,
   input  logic [11:0]    Dest,
   input  logic [4*W-1:0] Data,
   input  logic           Hold,
   output logic [3:0]     Gnt,
   output logic [7:0]     Ld_Reg,
   output logic [W-1:0]   Bus,
   output logic           Busy
);

   logic [3:0]   gnt_q, gnt_d;
   logic [7:0]   ld_q, ld_d;
   logic [W-1:0] bus_q, bus_d;
   logic [1:0]   ptr_q, ptr_d;

   logic [3:0]   elig;
   logic         win_vld;
   logic [1:0]   win_idx;
   logic [1:0]   cand;
   logic [2:0]   win_dest;
   logic [W-1:0] win_data;

   // The requester granted this cycle is masked so a held Req is not granted twice.
   always_comb begin
      elig    = Req & ~gnt_q;
      win_vld = 1'b0;
      win_idx = ptr_q;
      cand    = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_vld && elig[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
      if (Hold) begin
         win_vld = 1'b0;
      end
   end

   always_comb begin
      win_dest = 3'd0;
      win_data = '0;
      for (int i = 0; i < 4; i++) begin
         if (win_idx == 2'(i)) begin
            win_dest = Dest[3*i +: 3];
            win_data = Data[W*i +: W];
         end
      end
   end

   always_comb begin
      gnt_d = 4'b0000;
      ld_d  = 8'b0000_0000;
      bus_d = bus_q;
      ptr_d = ptr_q;
      if (win_vld) begin
         gnt_d = 4'b0001 << win_idx;
         ld_d  = 8'b0000_0001 << win_dest;
         bus_d = win_data;
         ptr_d = win_idx + 2'd1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         gnt_q <= 4'b0000;
         ld_q  <= 8'b0000_0000;
         bus_q <= '0;
         ptr_q <= 2'd0;
      end else begin
         gnt_q <= gnt_d;
         ld_q  <= ld_d;
         bus_q <= bus_d;
         ptr_q <= ptr_d;
      end
   end

   assign Gnt    = gnt_q;
   assign Ld_Reg = ld_q;
   assign Bus    = bus_q;
   assign Busy   = (|elig) && (Hold || ($countones(elig) > 1));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a per-cycle reference model.
module tb_regfile_write_arbiter;
   localparam int W = 16;

   logic           Clk;
   logic           Reset;
   logic [3:0]     Req;
   logic [11:0]    Dest;
   logic [4*W-1:0] Data;
   logic           Hold;
   logic [3:0]     Gnt;
   logic [7:0]     Ld_Reg;
   logic [W-1:0]   Bus;
   logic           Busy;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 0;

   regfile_write_arbiter #(.W(W)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Dest(Dest), .Data(Data),
      .Hold(Hold), .Gnt(Gnt), .Ld_Reg(Ld_Reg), .Bus(Bus), .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who holds the grant, where the pointer sits, what is on the bus.
   int           m_ptr = 0;
   int           m_gi  = -1;
   logic [7:0]   m_ld  = 8'h00;
   logic [W-1:0] m_bus = '0;

   always @(posedge Clk or negedge Reset) begin
      int w;
      if (!Reset) begin
         m_ptr = 0; m_gi = -1; m_ld = 8'h00; m_bus = '0;
      end else begin
         w = -1;
         if (!Hold) begin
            for (int k = 0; k < 4; k++) begin
               int c;
               c = (m_ptr + k) % 4;
               if (w < 0 && Req[c] && c != m_gi) w = c;
            end
         end
         if (w >= 0) begin
            m_gi  = w;
            m_ld  = 8'h01 << Dest[3*w +: 3];
            m_bus = Data[W*w +: W];
            m_ptr = (w + 1) % 4;
         end else begin
            m_gi = -1;
            m_ld = 8'h00;
         end
      end
   end

   function automatic logic model_busy();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 4; i++) if (Req[i] && i != m_gi) cnt++;
      return (cnt > 0) && (Hold || cnt > 1);
   endfunction

   always @(negedge Clk) begin
      if (cmp_en) begin
         chk("m_gnt", 32'(Gnt), (m_gi < 0) ? 32'h0 : (32'h1 << m_gi));
         chk("m_ld",  32'(Ld_Reg), 32'(m_ld));
         chk("m_bus", 32'(Bus), 32'(m_bus));
         chk("m_busy", 32'(Busy), 32'(model_busy()));
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset = 1'b0; Req = 4'b0; Dest = '0; Data = '0; Hold = 1'b0;
      #2;
      chk("rst_gnt", 32'(Gnt), 32'h0);
      chk("rst_ld",  32'(Ld_Reg), 32'h0);
      chk("rst_bus", 32'(Bus), 32'h0);
      cmp_en = 1;
      step(); step();
      Reset = 1'b1;

      // Idle
      repeat (5) step();
      at_neg();
      chk("idle_busy", 32'(Busy), 32'h0);
      chk("idle_gnt", 32'(Gnt), 32'h0);

      // Single write from requester 1
      step();
      Req = 4'b0010; Dest[5:3] = 3'd5; Data[31:16] = 16'hBEEF;
      at_neg();
      chk("single_busy_pre", 32'(Busy), 32'h0);
      step();
      chk("single_gnt", 32'(Gnt), 32'h2);
      chk("single_ld",  32'(Ld_Reg), 32'h20);
      chk("single_bus", 32'(Bus), 32'hBEEF);
      step();
      chk("single_gnt_off", 32'(Gnt), 32'h0);
      Req = 4'b0000;

      // Round-robin from a fresh pointer
      step();
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      Dest = {3'd7, 3'd2, 3'd4, 3'd1};
      Data = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
      Req  = 4'b1111;
      step();
      chk("rr0_gnt", 32'(Gnt), 32'h1);
      chk("rr0_bus", 32'(Bus), 32'hA000);
      chk("rr0_ld",  32'(Ld_Reg), 32'h02);
      step();
      chk("rr1_gnt", 32'(Gnt), 32'h2);
      chk("rr1_bus", 32'(Bus), 32'hB111);
      step();
      chk("rr2_gnt", 32'(Gnt), 32'h4);
      chk("rr2_bus", 32'(Bus), 32'hC222);
      step();
      chk("rr3_gnt", 32'(Gnt), 32'h8);
      chk("rr3_bus", 32'(Bus), 32'hD333);
      chk("rr3_ld",  32'(Ld_Reg), 32'h80);
      step();
      chk("rr4_gnt", 32'(Gnt), 32'h1);
      Req = 4'b0000;
      step();

      // Pointer now at 1: grant 2 alone, then 0101 wraps to 0 before 2
      Req = 4'b0100;
      step();
      chk("wrap_g2", 32'(Gnt), 32'h4);
      Req = 4'b0101;
      step();
      chk("wrap_g0", 32'(Gnt), 32'h1);
      chk("wrap_bus0", 32'(Bus), 32'hA000);
      Req = 4'b0100;
      step();
      chk("wrap_g2b", 32'(Gnt), 32'h4);
      Req = 4'b0000;
      step();

      // Hold blocks new grants
      Req = 4'b1000; Hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         chk("hold_busy", 32'(Busy), 32'h1);
         chk("hold_gnt", 32'(Gnt), 32'h0);
         step();
      end
      Hold = 1'b0;
      at_neg();
      chk("hold_gnt_pre", 32'(Gnt), 32'h0);
      step();
      chk("hold_release_gnt", 32'(Gnt), 32'h8);
      chk("hold_release_bus", 32'(Bus), 32'hD333);
      Req = 4'b0000;
      step();

      // Reset mid-stream during a grant to requester 2
      Req = 4'b1111;
      begin
         bit seen;
         seen = 0;
         for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (Gnt == 4'b0100) seen = 1;
         end
         total++;
         if (!seen) begin
            bad++;
            $display("FAIL stream_gnt2 got=not_seen want=4");
         end
      end
      #2;
      Reset = 1'b0;
      #1;
      chk("midrst_gnt", 32'(Gnt), 32'h0);
      chk("midrst_ld",  32'(Ld_Reg), 32'h0);
      chk("midrst_bus", 32'(Bus), 32'h0);
      step();
      Reset = 1'b1;
      step();
      chk("post_rst_gnt", 32'(Gnt), 32'h1);
      chk("post_rst_bus", 32'(Bus), 32'hA000);
      Req = 4'b0000;
      step(); step();
      cmp_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the SLC-3 register file among four requesters (e.g. ALU result, MDR load, PC-link, debug/switch load). Each cycle it selects at most one pending request, and drives that requester's data onto a registered write bus. It also raises exactly one one-hot load strobe toward the `register` instances of the register file. It sits between the datapath sources and the eight general-purpose `register` instances, replacing ad-hoc per-source load muxing.

## Interface
- `W`, 16, data width of the bus and registers
- `Clk`  in  1  system clock; all state changes on its rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Req`  in  4  request per requester, bit i = requester i
- `Dest`  in  12  destination register per requester, requester i at bits [3i+2:3i]
- `Data`  in  4*W  write data per requester, requester i at bits [W*i+W-1:W*i]
- `Hold`  in  1  stall from the control FSM; no new grant issued while high
- `Gnt`  out  4  one-hot grant, high for exactly one cycle per granted request
- `Ld_Reg`  out  8  one-hot load strobe, bit k loads register Rk
- `Bus`  out  W  registered write data for the register file
- `Busy`  out  1  high when any `Req` is pending but not granted this cycle

## Operation
- State:
  - Round-robin pointer `ptr` (2 bits): the requester with highest priority next.
  - Registered `Gnt`, `Ld_Reg` and `Bus`.
- Arbitration, evaluated combinationally in cycle t from `Req`, `Hold`, `ptr` and the current `Gnt`:
  - Eligible set = `Req & ~Gnt`. The currently granted requester is masked so that a request still asserted during its grant cycle is not granted twice.
  - If `Hold` = 1 or the eligible set is empty, no winner.
  - Otherwise the winner is the first eligible index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- On the edge ending cycle t, when there is a winner i:
  - `Gnt` <= one-hot(i).
  - `Ld_Reg` <= one-hot(`Dest`[i]).
  - `Bus` <= `Data`[i].
  - `ptr` <= (i+1) mod 4; wraps from 3 to 0.
- On the edge ending cycle t, when there is no winner: `Gnt` <= 0, `Ld_Reg` <= 0, `Bus` holds its value, `ptr` holds.
- Requester protocol:
  - Keep `Req`, `Dest` and `Data` stable from assertion until `Gnt` is seen.
  - Deassert `Req` in the cycle after `Gnt`, or keep it high for a new write with new `Dest`/`Data` presented.
- `Busy` is combinational: `|(Req & ~Gnt)` while no winner exists, or while more than one requester is eligible.
- Invariants:
  - `Gnt` is zero or one-hot.
  - `Ld_Reg` is nonzero exactly when `Gnt` is nonzero.
- `Hold` does not cancel a grant already registered. The current `Gnt`/`Ld_Reg` cycle completes.

## Timing
- Reset (`Reset` = 0, asynchronous, immediate): `Gnt` = 0, `Ld_Reg` = 0, `Bus` = 0, `ptr` = 0. Outputs hold these values while `Reset` is low.
- Reset asserted during a grant cycle clears `Gnt`/`Ld_Reg` immediately; that write is lost. After deassertion the requester must re-present `Req`.
- Latency: `Req` high in cycle t, winner → `Gnt`/`Ld_Reg`/`Bus` valid in cycle t+1 → register Rk captures `Bus` on the edge ending t+1.
- Throughput: one write per cycle when at least two requesters are active.
- A single continuously requesting source is granted every other cycle because of the self-mask.
- Worst-case wait for a stable request with `Hold` = 0 is 4 grant cycles.
- `Hold` is sampled in the same cycle as `Req`. `Hold` high in cycle t means no grant in t+1.

## Test plan
- Reset and idle: drive `Reset` low mid-cycle → `Gnt` = 0, `Ld_Reg` = 0, `Bus` = 0 without waiting for a clock edge. After release with `Req` = 0000 for 5 cycles → outputs stay 0 and `Busy` = 0.
- Single write: `Req` = 0010, `Dest`[1] = 5, `Data`[1] = 16'hBEEF at cycle t → at t+1 `Gnt` = 0010, `Ld_Reg` = 8'b0010_0000, `Bus` = 16'hBEEF. At t+2 `Gnt` = 0 even though `Req` is still high.
- Round-robin fairness: `Req` = 1111 held stable from reset → grant order 0, 1, 2, 3, 0, … with `Gnt` = 0001, 0010, 0100, 1000, 0001 on consecutive cycles. Each cycle's `Bus` = `Data` of that requester.
- Wrap and skip: `ptr` = 3 after granting requester 2, `Req` = 0101 → requester 0 is granted next, then requester 2.
- Hold: `Req` = 1000 with `Hold` = 1 for 3 cycles → no grant and `Busy` = 1. `Hold` drops at cycle t → `Gnt` = 1000 at t+1.
- Reset mid-stream: `Req` = 1111 streaming, `Reset` pulsed low during a `Gnt` = 0100 cycle → outputs clear immediately. After release, the first grant goes to requester 0.
